// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 4-digit display scanner:
// FSM state encoding, active-low segment patterns and digit slot indices.
package display_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Segment patterns ordered {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit slots; the index doubles as the anode bit position.
  localparam logic [1:0] DIG_SEC_R = 2'd0;
  localparam logic [1:0] DIG_SEC_L = 2'd1;
  localparam logic [1:0] DIG_MIN_R = 2'd2;
  localparam logic [1:0] DIG_MIN_L = 2'd3;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not valid BCD and render as a dark digit.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Map one BCD digit to its segment pattern.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scanner for a 4-digit common-anode display (mm:ss).
// Each digit is preceded by BLANK_CYCLES dark cycles to suppress ghosting;
// the four digit values are sampled once per frame so a frame never mixes
// old and new values. Optional feature macro: DISPLAY_BLINK_EN enables
// blinking of the minute or second pair while in adjust mode.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_scan,
  input  logic       tick_blink,
  input  logic       adj,
  input  logic       sel,
  input  logic [3:0] min_l,
  input  logic [3:0] min_r,
  input  logic [3:0] sec_l,
  input  logic [3:0] sec_r,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_idx
);

  localparam logic [7:0] LP_CNT_LAST = 8'(BLANK_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [15:0] r_snap, w_snap_nxt;
  logic [3:0]  r_an, w_an_nxt;
  logic [6:0]  r_seg, w_seg_nxt;
  logic [6:0]  w_seg_dec;
  logic [3:0]  w_digit;
  logic        w_hide;

  // Next-state logic: blank countdown, scan advance and frame snapshot.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_snap_nxt  = r_snap;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = 8'd0;
          if (r_idx == DIG_SEC_R) begin
            w_snap_nxt = {min_l, min_r, sec_l, sec_r};
          end else begin
            w_snap_nxt = r_snap;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_SHOW: begin
        if (tick_scan) begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = r_idx + 2'd1;
        end else begin
          w_state_nxt = ST_SHOW;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Decode the digit that will be on screen after this edge.
  assign w_digit = w_snap_nxt[{w_idx_nxt, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

`ifdef DISPLAY_BLINK_EN
  logic r_blink, w_blink_nxt;

  // Blink phase toggles only in adjust mode and is forced low outside it.
  always_comb begin
    if (!adj) begin
      w_blink_nxt = 1'b0;
    end else if (tick_blink) begin
      w_blink_nxt = ~r_blink;
    end else begin
      w_blink_nxt = r_blink;
    end
  end

  // Blink phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink <= 1'b0;
    end else begin
      r_blink <= w_blink_nxt;
    end
  end

  // sel=0 blinks the minute pair (slots 2,3), sel=1 the second pair (0,1).
  assign w_hide = w_blink_nxt & (sel ? ~w_idx_nxt[1] : w_idx_nxt[1]);
`else
  wire w_unused_blink = &{1'b0, tick_blink, adj, sel};
  assign w_hide = 1'b0;
`endif

  // Output pattern derived from the next state so an/seg stay registered.
  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_BLANK;
    if (w_state_nxt == ST_SHOW) begin
      w_seg_nxt = w_seg_dec;
      if (w_hide) begin
        w_an_nxt = AN_OFF;
      end else begin
        w_an_nxt = ~(4'b0001 << w_idx_nxt);
      end
    end else begin
      w_an_nxt  = AN_OFF;
      w_seg_nxt = SEG_BLANK;
    end
  end

  // State, counters, snapshot and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= 8'd0;
      r_idx   <= DIG_SEC_R;
      r_snap  <= 16'd0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_snap  <= w_snap_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign digit_idx = r_idx;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl. Expected {an,seg,digit_idx}
// triples are pushed when a digit is scheduled and popped when it appears.
module tb_display_scan_ctrl;

  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_scan = 1'b0;
  logic       tick_blink = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] min_l = 4'd0, min_r = 4'd0, sec_l = 4'd0, sec_r = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digit_idx;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_q[$];
  logic [1:0]  m_idx = 2'd0;
  logic [15:0] m_snap = 16'd0;
  logic        m_blink = 1'b0;

  display_scan_ctrl #(.BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_scan  (tick_scan),
    .tick_blink (tick_blink),
    .adj        (adj),
    .sel        (sel),
    .min_l      (min_l),
    .min_r      (min_r),
    .sec_l      (sec_l),
    .sec_r      (sec_r),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic push_exp();
    logic [3:0] d;
    logic [3:0] a;
    logic hid;
    d = m_snap[{m_idx, 2'b00} +: 4];
    hid = m_blink && (sel ? (m_idx < 2'd2) : (m_idx >= 2'd2));
    a = hid ? 4'hF : ~(4'b0001 << m_idx);
    exp_q.push_back({a, ref_seg(d), m_idx});
  endtask

  // Schedule the next digit in the model, pulse tick_scan, measure dark time.
  task automatic scan_step(input bit drop, input bit blink_too,
                           output int dark, output bit shown, output logic [12:0] obs);
    m_idx = m_idx + 2'd1;
    if (m_idx == 2'd0) m_snap = {min_l, min_r, sec_l, sec_r};
`ifdef DISPLAY_BLINK_EN
    if (blink_too && adj) m_blink = ~m_blink;
`endif
    push_exp();
    tick_scan = 1'b1;
    tick_blink = blink_too;
    @(negedge clk);
    tick_scan = 1'b0;
    tick_blink = 1'b0;
    dark = 0;
    shown = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (an != 4'hF) begin
        shown = 1'b1;
        break;
      end
      dark++;
      tick_scan = (drop && i == 1);
      @(negedge clk);
    end
    tick_scan = 1'b0;
    obs = {an, seg, digit_idx};
  endtask

  task automatic test_reset();
    int dark;
    logic [12:0] e;
    rst = 1'b1;
    min_l = 4'd1; min_r = 4'd2; sec_l = 4'd3; sec_r = 4'd4;
    repeat (2) @(negedge clk);
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b exp 1111111", seg); end
    checks++;
    if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", digit_idx); end
    m_idx = 2'd0; m_snap = {min_l, min_r, sec_l, sec_r}; m_blink = 1'b0;
    push_exp();
    rst = 1'b0;
    dark = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (an != 4'hF) break;
      dark++;
    end
    e = exp_q.pop_front();
    checks++;
    if (dark != BC - 1) begin errors++; $display("FAIL reset_latency got %0d dark exp %0d", dark, BC - 1); end
    checks++;
    if ({an, seg, digit_idx} !== e)
      begin errors++; $display("FAIL reset_first got %b exp %b", {an, seg, digit_idx}, e); end
  endtask

  // Runs n scan steps, comparing each against the scoreboard and a hold check.
  task automatic run_steps(input string name, input int n, input bit drop, input bit blink_first);
    int dark;
    bit shown;
    logic [12:0] obs, e;
    for (int k = 0; k < n; k++) begin
      scan_step(drop, blink_first && k == 0, dark, shown, obs);
      e = exp_q.pop_front();
      checks++;
      if (e[12:9] == 4'hF) begin
        if (shown) begin errors++; $display("FAIL %s_hidden step %0d shown an=%b", name, k, obs[12:9]); end
      end else if (!shown || dark != BC) begin
        errors++; $display("FAIL %s_dark step %0d got dark=%0d shown=%0d exp %0d", name, k, dark, shown, BC);
      end
      checks++;
      if (obs !== e) begin errors++; $display("FAIL %s_show step %0d got %b exp %b", name, k, obs, e); end
      repeat (5) @(negedge clk);
      checks++;
      if ({an, seg, digit_idx} !== e)
        begin errors++; $display("FAIL %s_hold step %0d got %b exp %b", name, k, {an, seg, digit_idx}, e); end
    end
  endtask

  task automatic test_scan_order();
    run_steps("scan", 4, 1'b0, 1'b0);
  endtask

  task automatic test_snapshot();
    run_steps("snap_pre", 1, 1'b0, 1'b0);
    min_r = 4'd5;
    sec_r = 4'd7;
    run_steps("snap", 5, 1'b0, 1'b0);
  endtask

  task automatic test_invalid_bcd();
    sec_l = 4'd12;
    run_steps("bcd", 3, 1'b0, 1'b0);
  endtask

  task automatic test_dropped_tick();
    run_steps("drop", 2, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int dark;
    logic [12:0] e;
    rst = 1'b1;
    tick_scan = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'hF || digit_idx !== 2'd0)
      begin errors++; $display("FAIL midrst got an=%b idx=%0d exp 1111 0", an, digit_idx); end
    rst = 1'b0;
    tick_scan = 1'b0;
    m_idx = 2'd0; m_snap = {min_l, min_r, sec_l, sec_r}; m_blink = 1'b0;
    push_exp();
    dark = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (an != 4'hF) break;
      dark++;
    end
    e = exp_q.pop_front();
    checks++;
    if (dark != BC - 1 || {an, seg, digit_idx} !== e)
      begin errors++; $display("FAIL midrst_restart got dark=%0d %b exp %0d %b", dark, {an, seg, digit_idx}, BC - 1, e); end
  endtask

`ifdef DISPLAY_BLINK_EN
  task automatic test_blink();
    adj = 1'b1;
    sel = 1'b0;
    tick_blink = 1'b1;
    @(negedge clk);
    tick_blink = 1'b0;
    m_blink = 1'b1;
    run_steps("blink_on", 5, 1'b0, 1'b0);
    run_steps("blink_off", 2, 1'b0, 1'b1);
    tick_blink = 1'b1;
    @(negedge clk);
    tick_blink = 1'b0;
    adj = 1'b0;
    @(negedge clk);
    m_blink = 1'b0;
    run_steps("blink_adj0", 4, 1'b0, 1'b0);
  endtask
`else
  task automatic test_blink();
    adj = 1'b1;
    sel = 1'b0;
    run_steps("blink_ignored", 4, 1'b0, 1'b1);
    adj = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_scan_order();
    test_snapshot();
    test_invalid_bcd();
    test_dropped_tick();
    test_reset_midframe();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 4: number of clk cycles with all anodes off between digits (range 1..255).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port tick_scan  in  1  one-cycle pulse; advance to next digit.
REQ-005 SHALL have port tick_blink  in  1  one-cycle pulse; toggle blink phase.
REQ-006 SHALL have port adj  in  1  adjust mode; enables blinking.
REQ-007 SHALL have port sel  in  1  blink target: 0 = minute digits, 1 = second digits.
REQ-008 SHALL have ports min_l, min_r, sec_l, sec_r  in  4 each  BCD digit values.
REQ-009 SHALL have port seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL have port an  out  4  anode enables, active-low, registered; an[0]=sec_r, an[1]=sec_l, an[2]=min_r, an[3]=min_l.
REQ-011 SHALL have port digit_idx  out  2  index of digit currently scheduled.

Function
REQ-012 FSM states SHALL be BLANK and SHOW.
REQ-013 In BLANK: an=4'b1111, seg=7'b1111111; count BLANK_CYCLES cycles, then enter SHOW.
REQ-014 In SHOW: exactly one an bit low (an[digit_idx]), seg = decode of snapshot digit digit_idx; hold until tick_scan.
REQ-015 tick_scan in SHOW SHALL enter BLANK next cycle and increment digit_idx modulo 4 (3 wraps to 0).
REQ-016 tick_scan in BLANK SHALL be ignored (dropped, not queued).
REQ-017 On BLANK->SHOW with digit_idx=0, all four inputs SHALL be captured into a snapshot; snapshot is held for the whole frame (no tearing).
REQ-018 Decode: 0..9 standard 7-seg (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000); values 10..15 SHALL show blank (7'b1111111).
REQ-019 Latency: first digit visible BLANK_CYCLES cycles after rst deasserts; inter-digit dark time exactly BLANK_CYCLES cycles after the tick_scan cycle.
REQ-020 tick_scan and tick_blink in the same cycle SHALL each take effect independently.

Reset
REQ-021 rst SHALL set state=BLANK, blank counter=0, digit_idx=0, snapshot=0, blink_phase=0, an=4'b1111, seg=7'b1111111.
REQ-022 rst asserted mid-frame SHALL override all other inputs in that cycle; scan restarts from digit 0.

Configuration
REQ-023 With macro DISPLAY_BLINK_EN defined: blink_phase toggles on tick_blink while adj=1; adj=0 clears blink_phase to 0 next cycle; when adj=1 and blink_phase=1, the sel-selected digit pair is shown with an bit high (dark) during its SHOW slot; timing unchanged.
REQ-024 Without DISPLAY_BLINK_EN: tick_blink, adj, sel are ignored; no blink_phase register exists; all digits always displayed.

Structure
REQ-025 A shared package display_pkg SHALL hold the state enum, segment pattern constants (digits 0-9, blank) and digit index constants.
REQ-026 BCD-to-segment decode SHALL be one combinational sub-module seg7_decode; the FSM, counters and snapshot stay in display_scan_ctrl.

Verification
REQ-027 Reset: rst high 2 cycles, inputs 1,2,3,4 -> an=1111, seg=7F; 4 cycles after release an=1110, seg=7'b0011001 (digit 4 = sec_r).
REQ-028 Scan order: min_l=1,min_r=2,sec_l=3,sec_r=4, tick_scan every 10 cycles -> an 1110,1101,1011,0111,1110 with segs 4,3,2,1,4; 4 dark cycles between each.
REQ-029 Snapshot: change sec_r 4->7 while digit_idx=2 -> digit 0 still shows 4 this frame, shows 7 only after the next wrap.
REQ-030 Invalid BCD: sec_l=12 -> during digit_idx=1 an=1101, seg=7'b1111111.
REQ-031 Blink (DISPLAY_BLINK_EN): adj=1, sel=0, one tick_blink -> an[3],an[2] stay high in their slots; second tick_blink restores; adj=0 -> always shown.
REQ-032 Dropped tick: tick_scan pulsed during BLANK -> digit_idx unchanged, SHOW entered after BLANK_CYCLES and held until the next tick_scan.
